// File: rtl/lsu_tlbrdret.sv
// lsu_tlbrdret: return path for TLB diagnostic reads (tag/data ASI loads).
// A read is latched on issue, its formatted result captured one cycle later,
// then held for the return arbiter until granted. Parity errors seen on
// captured reads are counted (saturating) and the first one is logged.
module lsu_tlbrdret #(
    parameter int DATA_W = 64
) (
    input  logic              rclk,
    input  logic              arst_l,
    input  logic              rd_req_g,
    input  logic [1:0]        rd_tid_g,
    input  logic              rd_data_sel_g,
    input  logic [DATA_W-1:0] lsu_tlb_rd_data,
    input  logic              tte_data_parity_error,
    input  logic              tte_tag_parity_error,
    input  logic              rd_flush_w,
    input  logic              ret_grant,
    input  logic              perr_log_clr,
    output logic              ret_req,
    output logic [1:0]        ret_tid,
    output logic [DATA_W-1:0] ret_data,
    output logic              ret_perr,
    output logic              busy,
    output logic [7:0]        perr_cnt,
    output logic              perr_log_vld,
    output logic [1:0]        perr_log_tid,
    output logic              perr_log_is_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        RET  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] lat_tid;
    logic       lat_sel;
    logic       accept;
    logic       capture;
    logic       sel_err;
    logic       cap_err;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        sat_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // State register; reset abandons any read in flight.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, accept/capture strobes and the combinational busy flag.
    // A grant in RET frees the block in the same cycle so a new read can
    // be taken without an idle bubble.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE) && !((state == RET) && ret_grant);
        accept    = rd_req_g && !busy;
        capture   = (state == CAPT) && !rd_flush_w;
        sel_err   = lat_sel ? tte_data_parity_error : tte_tag_parity_error;
        cap_err   = capture && sel_err;
        ret_req   = (state == RET);
        case (state)
            IDLE: if (rd_req_g) state_nxt = CAPT;
            CAPT: state_nxt = rd_flush_w ? IDLE : RET;
            RET: begin
                if (ret_grant) state_nxt = rd_req_g ? CAPT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the request attributes whenever a new read is accepted.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            lat_tid <= 2'd0;
            lat_sel <= 1'b0;
        end else if (accept) begin
            lat_tid <= rd_tid_g;
            lat_sel <= rd_data_sel_g;
        end
    end

    // Capture the read result; held unchanged through RET until granted.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ret_data <= '0;
            ret_tid  <= 2'd0;
            ret_perr <= 1'b0;
        end else if (capture) begin
            ret_data <= lsu_tlb_rd_data;
            ret_tid  <= lat_tid;
            ret_perr <= sel_err;
        end
    end

    // Error counter and first-error log; a clear coinciding with an error
    // restarts both from that error.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            perr_cnt         <= 8'd0;
            perr_log_vld     <= 1'b0;
            perr_log_tid     <= 2'd0;
            perr_log_is_data <= 1'b0;
        end else if (perr_log_clr) begin
            perr_cnt         <= cap_err ? 8'd1 : 8'd0;
            perr_log_vld     <= cap_err;
            perr_log_tid     <= cap_err ? lat_tid : 2'd0;
            perr_log_is_data <= cap_err ? lat_sel : 1'b0;
        end else if (cap_err) begin
            perr_cnt <= sat_inc(perr_cnt);
            if (!perr_log_vld) begin
                perr_log_vld     <= 1'b1;
                perr_log_tid     <= lat_tid;
                perr_log_is_data <= lat_sel;
            end
        end
    end

endmodule

// File: tb/tb_lsu_tlbrdret.sv
// Directed bench for lsu_tlbrdret: expected returns go into a scoreboard
// queue at capture time; a monitor pops and compares on each granted return.
module tb_lsu_tlbrdret;

    logic        rclk;
    logic        arst_l;
    logic        rd_req_g;
    logic [1:0]  rd_tid_g;
    logic        rd_data_sel_g;
    logic [63:0] lsu_tlb_rd_data;
    logic        tte_data_parity_error;
    logic        tte_tag_parity_error;
    logic        rd_flush_w;
    logic        ret_grant;
    logic        perr_log_clr;
    logic        ret_req;
    logic [1:0]  ret_tid;
    logic [63:0] ret_data;
    logic        ret_perr;
    logic        busy;
    logic [7:0]  perr_cnt;
    logic        perr_log_vld;
    logic [1:0]  perr_log_tid;
    logic        perr_log_is_data;

    typedef struct {
        logic [1:0]  tid;
        logic [63:0] data;
        logic        perr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    lsu_tlbrdret dut (
        .rclk                 (rclk),
        .arst_l               (arst_l),
        .rd_req_g             (rd_req_g),
        .rd_tid_g             (rd_tid_g),
        .rd_data_sel_g        (rd_data_sel_g),
        .lsu_tlb_rd_data      (lsu_tlb_rd_data),
        .tte_data_parity_error(tte_data_parity_error),
        .tte_tag_parity_error (tte_tag_parity_error),
        .rd_flush_w           (rd_flush_w),
        .ret_grant            (ret_grant),
        .perr_log_clr         (perr_log_clr),
        .ret_req              (ret_req),
        .ret_tid              (ret_tid),
        .ret_data             (ret_data),
        .ret_perr             (ret_perr),
        .busy                 (busy),
        .perr_cnt             (perr_cnt),
        .perr_log_vld         (perr_log_vld),
        .perr_log_tid         (perr_log_tid),
        .perr_log_is_data     (perr_log_is_data)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [1:0] tid, input logic [63:0] data, input logic perr);
        exp_t e;
        e.tid  = tid;
        e.data = data;
        e.perr = perr;
        sb.push_back(e);
    endtask

    // Monitor: every granted return must match the oldest expected entry.
    always @(negedge rclk) begin
        if (arst_l && ret_req && ret_grant) begin
            if (sb.size() == 0) begin
                chk("unexpected_return", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_ret_tid", 64'(ret_tid), 64'(e.tid));
                chk("mon_ret_data", ret_data, e.data);
                chk("mon_ret_perr", 64'(ret_perr), 64'(e.perr));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_l = 1'b0;
        rd_req_g = 1'b0;
        rd_tid_g = 2'd0;
        rd_data_sel_g = 1'b0;
        lsu_tlb_rd_data = 64'd0;
        tte_data_parity_error = 1'b0;
        tte_tag_parity_error = 1'b0;
        rd_flush_w = 1'b0;
        ret_grant = 1'b0;
        perr_log_clr = 1'b0;
        #3;
        chk("rst_ret_req", 64'(ret_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_perr_cnt", 64'(perr_cnt), 64'd0);
        chk("rst_log_vld", 64'(perr_log_vld), 64'd0);
        chk("rst_ret_data", ret_data, 64'd0);
        #9;
        arst_l = 1'b1;
        cyc();

        // Tag read: the data-error input must be ignored.
        rd_req_g = 1'b1; rd_tid_g = 2'd2; rd_data_sel_g = 1'b0;
        cyc();
        rd_req_g = 1'b0;
        lsu_tlb_rd_data = 64'hA5A5_0000_1234_5678;
        tte_tag_parity_error = 1'b0; tte_data_parity_error = 1'b1;
        push(2'd2, 64'hA5A5_0000_1234_5678, 1'b0);
        chk("capt_busy", 64'(busy), 64'd1);
        cyc();
        tte_data_parity_error = 1'b0;
        chk("tag_ret_req", 64'(ret_req), 64'd1);
        chk("tag_ret_perr", 64'(ret_perr), 64'd0);
        chk("tag_perr_cnt", 64'(perr_cnt), 64'd0);
        ret_grant = 1'b1;
        cyc();
        ret_grant = 1'b0;
        chk("tag_ret_req_low", 64'(ret_req), 64'd0);

        // Data read with error, grant delayed three cycles.
        rd_req_g = 1'b1; rd_tid_g = 2'd1; rd_data_sel_g = 1'b1;
        cyc();
        rd_req_g = 1'b0;
        lsu_tlb_rd_data = 64'hDEAD_BEEF_0BAD_F00D;
        tte_data_parity_error = 1'b1; tte_tag_parity_error = 1'b0;
        push(2'd1, 64'hDEAD_BEEF_0BAD_F00D, 1'b1);
        cyc();
        tte_data_parity_error = 1'b0;
        lsu_tlb_rd_data = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 4; i++) begin
            chk("hold_ret_req", 64'(ret_req), 64'd1);
            chk("hold_ret_data", ret_data, 64'hDEAD_BEEF_0BAD_F00D);
            ret_grant = (i == 3);
            cyc();
        end
        ret_grant = 1'b0;
        chk("data_ret_req_low", 64'(ret_req), 64'd0);
        chk("data_perr_cnt", 64'(perr_cnt), 64'd1);
        chk("data_log_vld", 64'(perr_log_vld), 64'd1);
        chk("data_log_tid", 64'(perr_log_tid), 64'd1);
        chk("data_log_is_data", 64'(perr_log_is_data), 64'd1);

        // Flush in the capture cycle: nothing returned or counted.
        rd_req_g = 1'b1; rd_tid_g = 2'd0; rd_data_sel_g = 1'b1;
        cyc();
        rd_req_g = 1'b0;
        rd_flush_w = 1'b1; tte_data_parity_error = 1'b1;
        cyc();
        rd_flush_w = 1'b0; tte_data_parity_error = 1'b0;
        chk("flush_ret_req", 64'(ret_req), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_perr_cnt", 64'(perr_cnt), 64'd1);

        // Back-to-back: grant and new request in the same cycle.
        rd_req_g = 1'b1; rd_tid_g = 2'd0; rd_data_sel_g = 1'b0;
        cyc();
        rd_req_g = 1'b0;
        lsu_tlb_rd_data = 64'h1111_2222_3333_4444;
        push(2'd0, 64'h1111_2222_3333_4444, 1'b0);
        cyc();
        ret_grant = 1'b1; rd_req_g = 1'b1; rd_tid_g = 2'd3; rd_data_sel_g = 1'b0;
        #1;
        chk("b2b_busy", 64'(busy), 64'd0);
        cyc();
        ret_grant = 1'b0;
        rd_tid_g = 2'd1;  // held request while busy must be ignored
        chk("b2b_ret_req_gap", 64'(ret_req), 64'd0);
        lsu_tlb_rd_data = 64'h3333_0000_0000_0003;
        push(2'd3, 64'h3333_0000_0000_0003, 1'b0);
        cyc();
        rd_req_g = 1'b0;
        chk("b2b_ret_req", 64'(ret_req), 64'd1);
        chk("b2b_ret_tid", 64'(ret_tid), 64'd3);
        ret_grant = 1'b1;
        cyc();
        ret_grant = 1'b0;
        chk("b2b_idle_busy", 64'(busy), 64'd0);

        // Saturation: 257 more tag-error reads on top of the existing count.
        for (int i = 0; i < 257; i++) begin
            rd_req_g = 1'b1; rd_tid_g = 2'd2; rd_data_sel_g = 1'b0;
            cyc();
            rd_req_g = 1'b0;
            lsu_tlb_rd_data = 64'(i);
            tte_tag_parity_error = 1'b1;
            push(2'd2, 64'(i), 1'b1);
            cyc();
            tte_tag_parity_error = 1'b0;
            ret_grant = 1'b1;
            cyc();
            ret_grant = 1'b0;
        end
        chk("sat_perr_cnt", 64'(perr_cnt), 64'hFF);
        chk("sat_log_tid_kept", 64'(perr_log_tid), 64'd1);
        chk("sat_log_is_data_kept", 64'(perr_log_is_data), 64'd1);

        // Clear coinciding with a capture error.
        rd_req_g = 1'b1; rd_tid_g = 2'd3; rd_data_sel_g = 1'b1;
        cyc();
        rd_req_g = 1'b0;
        lsu_tlb_rd_data = 64'hC1EA_0000_0000_0001;
        tte_data_parity_error = 1'b1; perr_log_clr = 1'b1;
        push(2'd3, 64'hC1EA_0000_0000_0001, 1'b1);
        cyc();
        tte_data_parity_error = 1'b0; perr_log_clr = 1'b0;
        chk("clr_perr_cnt", 64'(perr_cnt), 64'd1);
        chk("clr_log_vld", 64'(perr_log_vld), 64'd1);
        chk("clr_log_tid", 64'(perr_log_tid), 64'd3);
        chk("clr_log_is_data", 64'(perr_log_is_data), 64'd1);
        ret_grant = 1'b1;
        cyc();
        ret_grant = 1'b0;

        // Reset while a return is pending.
        rd_req_g = 1'b1; rd_tid_g = 2'd1; rd_data_sel_g = 1'b0;
        cyc();
        rd_req_g = 1'b0;
        lsu_tlb_rd_data = 64'hFFFF_0000_FFFF_0000;
        tte_tag_parity_error = 1'b1;
        cyc();
        tte_tag_parity_error = 1'b0;
        chk("pre_rst_ret_req", 64'(ret_req), 64'd1);
        #1;
        arst_l = 1'b0;
        #1;
        chk("arst_ret_req", 64'(ret_req), 64'd0);
        chk("arst_ret_data", ret_data, 64'd0);
        chk("arst_ret_tid", 64'(ret_tid), 64'd0);
        chk("arst_ret_perr", 64'(ret_perr), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_perr_cnt", 64'(perr_cnt), 64'd0);
        chk("arst_log_vld", 64'(perr_log_vld), 64'd0);
        chk("arst_log_tid", 64'(perr_log_tid), 64'd0);
        rd_req_g = 1'b1; rd_tid_g = 2'd2; rd_data_sel_g = 1'b1;
        #2;
        arst_l = 1'b1;
        cyc();
        rd_req_g = 1'b0;
        chk("post_rst_busy", 64'(busy), 64'd1);
        lsu_tlb_rd_data = 64'h5EED_5EED_5EED_5EED;
        push(2'd2, 64'h5EED_5EED_5EED_5EED, 1'b0);
        cyc();
        chk("post_rst_ret_req", 64'(ret_req), 64'd1);
        ret_grant = 1'b1;
        cyc();
        ret_grant = 1'b0;
        cyc();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
